// File: rtl/pipe_reg_chain.sv
// Multi-stage valid/ready register pipeline with bubble collapse, synchronous
// flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] prev_v;
  logic [WIDTH-1:0] prev_d [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // Advance chain: a stage loads when it is empty or its content moves on.
  always_comb begin
    logic acc;
    acc = i_ready;
    adv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc | ~v_q[k];
      adv[k] = acc;
    end
  end

  // Incoming beat for each stage: upstream port for stage 0, predecessor otherwise.
  always_comb begin
    prev_v    = '0;
    prev_v[0] = i_valid;
    prev_d[0] = i_data;
    for (int k = 1; k < DEPTH; k++) begin
      prev_v[k] = v_q[k-1];
      prev_d[k] = d_q[k-1];
    end
  end

  assign o_ready     = adv[0] & ~i_flush;
  assign o_valid     = v_q[DEPTH-1] & ~i_flush;
  assign o_data      = d_q[DEPTH-1];
  assign o_occupancy = occ_q;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Next-state: shift advancing stages; data only captured with a valid beat.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (i_flush) begin
      v_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_d[k] = prev_v[k];
          if (prev_v[k]) begin
            d_d[k] = prev_d[k];
          end
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (i_flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

endmodule
